// File: rtl/silu_stream_ctrl_pkg.sv
// Shared definitions for the SiLU stream controller slice.
// - DATA_WIDTH : element width owned by the SiLU lane
// - SILU_LAT   : default lane pipeline depth; must match the lane array
// - state_t / ST_* : 2-bit controller state encoding
// - clog2_min1 : pointer-width helper that never returns zero
package silu_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned SILU_LAT   = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/silu_stream_ctrl_if.sv
// Buffer-side bus of the SiLU stream controller.
// - rd_en/rd_addr/rd_data : source read port, data one cycle after rd_en
// - wr_valid/wr_ready/wr_addr/wr_data : stallable destination write port
// Modports: master = controller, slave = buffer.
interface silu_stream_ctrl_if
  import silu_pkg::*;
#(
  parameter int unsigned SIZE       = 4,
  parameter int unsigned DATA_WIDTH = silu_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = 12
);

  logic                         rd_en;
  logic [ADDR_WIDTH-1:0]        rd_addr;
  logic [SIZE*DATA_WIDTH-1:0]   rd_data;
  logic                         wr_valid;
  logic                         wr_ready;
  logic [ADDR_WIDTH-1:0]        wr_addr;
  logic [SIZE*DATA_WIDTH-1:0]   wr_data;

  modport master (
    output rd_en, rd_addr, wr_valid, wr_addr, wr_data,
    input  rd_data, wr_ready
  );

  modport slave (
    input  rd_en, rd_addr, wr_valid, wr_addr, wr_data,
    output rd_data, wr_ready
  );

endinterface

// File: rtl/silu_stream_ctrl_out_fifo.sv
// Synchronous output FIFO with a registered head.
// - clk, reset         : clock, synchronous active-high reset
// - push, din          : enqueue (caller guarantees no overflow)
// - pop                : dequeue head (ignored when empty)
// - head, valid, count : registered head word, non-empty flag, occupancy
module silu_out_fifo
  import silu_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned PW = clog2_min1(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             pop_ok;
  logic             store_we;
  logic             head_from_din;
  logic             head_from_store;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  // The head lives in its own register; the array holds entries 2..count.
  // A push bypasses the array whenever the head slot is (or becomes) free.
  always_comb begin
    pop_ok          = pop && valid;
    head_from_din   = push && ((count == '0) || (pop_ok && count == CW'(1)));
    head_from_store = pop_ok && (count > CW'(1));
    store_we        = push && !head_from_din;
  end

  assign valid = (count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      head   <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (head_from_din)
        head <= din;
      else if (head_from_store)
        head <= store[rd_ptr];
      if (head_from_store)
        rd_ptr <= nxt(rd_ptr);
      if (store_we)
        wr_ptr <= nxt(wr_ptr);
      if (push && !pop_ok)
        count <= count + CW'(1);
      else if (!push && pop_ok)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (store_we)
      store[wr_ptr] <= din;
  end

endmodule

// File: rtl/silu_stream_ctrl.sv
// Streams cfg_len packed words from a source region through an external
// SiLU lane array (fixed SILU_LAT, never stalled) into a destination region.
// - clk, reset : clock, synchronous active-high reset
// - start, cfg_src_base, cfg_dst_base, cfg_len : run request, sampled in IDLE
// - busy, done : run status, done is a one-cycle pulse
// - bus        : buffer read/write port (master side)
// - silu_x, silu_y : lane inputs (copy of rd_data) and lane outputs
module silu_stream_ctrl #(
  parameter int unsigned SIZE       = 4,
  parameter int unsigned DATA_WIDTH = silu_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned SILU_LAT   = silu_pkg::SILU_LAT,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       cfg_src_base,
  input  logic [ADDR_WIDTH-1:0]       cfg_dst_base,
  input  logic [ADDR_WIDTH:0]         cfg_len,
  output logic                        busy,
  output logic                        done,
  silu_stream_ctrl_if.master          bus,
  output logic [SIZE*DATA_WIDTH-1:0]  silu_x,
  input  logic [SIZE*DATA_WIDTH-1:0]  silu_y
);

  import silu_pkg::*;

  localparam int unsigned W  = SIZE*DATA_WIDTH;
  localparam int unsigned CW = $clog2(FIFO_DEPTH+1);
  localparam int unsigned SW = $clog2(FIFO_DEPTH+SILU_LAT+2);

  state_t                state;
  logic [ADDR_WIDTH-1:0] src_base;
  logic [ADDR_WIDTH-1:0] dst_base;
  logic [ADDR_WIDTH:0]   len;
  logic [ADDR_WIDTH:0]   issued;
  logic [ADDR_WIDTH:0]   written;
  logic [SILU_LAT:0]     tag;
  logic [CW-1:0]         fifo_count;
  logic [SW-1:0]         inflight;
  logic [SW-1:0]         occupancy;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  fifo_valid;
  logic [W-1:0]          fifo_head;

  // Credit: every word already issued but not yet written holds a FIFO slot,
  // so the push at the tag exit can never find the FIFO full.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i <= SILU_LAT; i++)
      inflight = inflight + SW'(tag[i]);
    occupancy = inflight + SW'(fifo_count);
    issue     = (state == ST_RUN) && (issued < len) && (occupancy < SW'(FIFO_DEPTH));
  end

  assign push = tag[SILU_LAT];
  assign pop  = fifo_valid && bus.wr_ready;

  assign bus.rd_en    = issue;
  assign bus.rd_addr  = src_base + issued[ADDR_WIDTH-1:0];
  assign bus.wr_valid = fifo_valid;
  assign bus.wr_data  = fifo_head;
  assign bus.wr_addr  = dst_base + written[ADDR_WIDTH-1:0];
  assign silu_x       = bus.rd_data;
  assign busy         = (state == ST_RUN) || (state == ST_DRAIN);
  assign done         = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      src_base <= '0;
      dst_base <= '0;
      len      <= '0;
      issued   <= '0;
      written  <= '0;
      tag      <= '0;
    end else begin
      tag     <= {tag[SILU_LAT-1:0], issue};
      issued  <= issued + {{ADDR_WIDTH{1'b0}}, issue};
      written <= written + {{ADDR_WIDTH{1'b0}}, pop};
      case (state)
        ST_IDLE: begin
          if (start) begin
            src_base <= cfg_src_base;
            dst_base <= cfg_dst_base;
            len      <= cfg_len;
            issued   <= '0;
            written  <= '0;
            state    <= (cfg_len == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN:   if (issued == len)  state <= ST_DRAIN;
        ST_DRAIN: if (written == len) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  silu_out_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (silu_y),
    .pop   (pop),
    .head  (fifo_head),
    .valid (fifo_valid),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_silu_stream_ctrl.sv
// Scoreboard bench for silu_stream_ctrl with a behavioural buffer and a
// behavioural SiLU lane pipeline (hard-swish style approximation in Q8.8).
module tb_silu_stream_ctrl;

  localparam int unsigned SIZE  = 4;
  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 12;
  localparam int unsigned LAT   = 3;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned W     = SIZE*DW;

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] cfg_src_base;
  logic [AW-1:0] cfg_dst_base;
  logic [AW:0]   cfg_len;
  logic          busy;
  logic          done;
  logic [W-1:0]  silu_x;
  logic [W-1:0]  silu_y;
  logic [W-1:0]  lane_pipe [LAT];

  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   wr_cnt = 0;
  int   outstanding = 0;
  logic rand_mode = 1'b0;
  logic ready_level = 1'b1;
  logic prev_stall = 1'b0;
  logic [W-1:0]  held_data;
  logic [AW-1:0] held_addr;

  exp_t          exp_q [$];
  logic [AW-1:0] rd_q [$];

  silu_stream_ctrl_if #(.SIZE(SIZE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  silu_stream_ctrl #(
    .SIZE       (SIZE),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .SILU_LAT   (LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cfg_src_base (cfg_src_base),
    .cfg_dst_base (cfg_dst_base),
    .cfg_len      (cfg_len),
    .busy         (busy),
    .done         (done),
    .bus          (bus),
    .silu_x       (silu_x),
    .silu_y       (silu_y)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] src_word(input logic [AW-1:0] a);
    logic [W-1:0] w;
    for (int i = 0; i < int'(SIZE); i++) begin
      int v;
      v = ((int'(a) * 29 + i * 517) % 3000) - 1500;
      w[i*DW +: DW] = 16'(v);
    end
    return w;
  endfunction

  function automatic logic [DW-1:0] silu_lane(input logic [DW-1:0] xr);
    logic signed [DW-1:0] x;
    int p;
    x = xr;
    if (x >= 16'sd1024) return xr;
    if (x <= -16'sd1024) return '0;
    p = int'(x) * (int'(x) + 1024);
    return 16'(p >>> 11);
  endfunction

  function automatic logic [W-1:0] silu_word(input logic [W-1:0] x);
    logic [W-1:0] y;
    for (int i = 0; i < int'(SIZE); i++)
      y[i*DW +: DW] = silu_lane(x[i*DW +: DW]);
    return y;
  endfunction

  // Source buffer: data valid the cycle after rd_en, garbage otherwise.
  always @(posedge clk) begin
    if (bus.rd_en)
      bus.rd_data <= src_word(bus.rd_addr);
    else
      bus.rd_data <= 64'hDEAD_BEEF_0BAD_F00D;
  end

  // Lane array stand-in: fixed latency, no enable.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(LAT); i++) lane_pipe[i] <= '0;
    end else begin
      lane_pipe[0] <= silu_word(silu_x);
      for (int i = 1; i < int'(LAT); i++) lane_pipe[i] <= lane_pipe[i-1];
    end
  end
  assign silu_y = lane_pipe[LAT-1];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor_step();
    exp_t e;
    logic [AW-1:0] ra;
    if (reset) begin
      exp_q.delete();
      rd_q.delete();
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (bus.rd_en) begin
        if (rd_q.size() == 0) begin
          check("rd_unexpected", 1, 0);
        end else begin
          ra = rd_q.pop_front();
          check("rd_addr", W'(bus.rd_addr), W'(ra));
        end
        outstanding++;
      end
      if (prev_stall && bus.wr_valid) begin
        check("stall_data_stable", bus.wr_data, held_data);
        check("stall_addr_stable", W'(bus.wr_addr), W'(held_addr));
      end
      if (bus.wr_valid && bus.wr_ready) begin
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", W'(bus.wr_addr), W'(e.addr));
          check("wr_data", bus.wr_data, e.data);
        end
        outstanding--;
        wr_cnt++;
      end
      if (outstanding > int'(DEPTH))
        check("credit_overflow", W'(outstanding), W'(DEPTH));
      if (done) done_cnt++;
      prev_stall = bus.wr_valid && !bus.wr_ready;
      held_data  = bus.wr_data;
      held_addr  = bus.wr_addr;
    end
  endtask

  task automatic launch(input logic [AW-1:0] src, input logic [AW-1:0] dst, input logic [AW:0] len);
    exp_t e;
    for (int i = 0; i < int'(len); i++) begin
      rd_q.push_back(src + AW'(i));
      e.addr = dst + AW'(i);
      e.data = silu_word(src_word(src + AW'(i)));
      exp_q.push_back(e);
    end
    cfg_src_base = src;
    cfg_dst_base = dst;
    cfg_len      = len;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int   n;
    logic pb;
    n  = 0;
    pb = 1'b0;
    while (!done && n < 3000) begin
      pb = busy;
      tick();
      n++;
    end
    if (!done) begin
      check({name, "_done_timeout"}, 0, 1);
    end else begin
      check({name, "_busy_at_done"}, W'(busy), 0);
      check({name, "_busy_before_done"}, W'(pb), 1);
    end
  endtask

  task automatic finish_run(input string name, input int d0, input int w0, input int len);
    repeat (3) tick();
    check({name, "_done_pulses"}, W'(done_cnt - d0), 1);
    check({name, "_write_count"}, W'(wr_cnt - w0), W'(len));
    check({name, "_scoreboard_empty"}, W'(exp_q.size()), 0);
  endtask

  task automatic stimulus();
    int   d0, w0, seen;
    logic got;
    reset = 1'b1; start = 1'b0;
    cfg_src_base = '0; cfg_dst_base = '0; cfg_len = '0;
    repeat (3) tick();
    check("rst_busy", W'(busy), 0);
    check("rst_done", W'(done), 0);
    check("rst_rd_en", W'(bus.rd_en), 0);
    check("rst_wr_valid", W'(bus.wr_valid), 0);
    check("rst_rd_addr", W'(bus.rd_addr), 0);
    check("rst_wr_addr", W'(bus.wr_addr), 0);
    reset = 1'b0;
    tick();

    // Basic run with latency and a hand-computed first word.
    d0 = done_cnt; w0 = wr_cnt;
    launch(12'h010, 12'h200, 13'd6);
    check("basic_first_rd_en", W'(bus.rd_en), 1);
    got = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      if (bus.wr_valid) begin
        got = 1'b1;
        check("basic_first_wr_cycle", W'(k), W'(3 + LAT));
        check("basic_first_wr_data", bus.wr_data, 64'h0183_FFFF_FF80_0000);
        check("basic_first_wr_addr", W'(bus.wr_addr), W'(12'h200));
      end else begin
        tick();
      end
    end
    if (!got) check("basic_first_wr_timeout", 0, 1);
    wait_done("basic");
    finish_run("basic", d0, w0, 6);

    // Backpressure mid-run.
    d0 = done_cnt; w0 = wr_cnt;
    launch(12'h100, 12'h300, 13'd20);
    repeat (8) tick();
    ready_level = 1'b0;
    repeat (12) tick();
    check("bp_rd_stopped", W'(bus.rd_en), 0);
    check("bp_outstanding_full", W'(outstanding), W'(DEPTH));
    ready_level = 1'b1;
    wait_done("bp");
    finish_run("bp", d0, w0, 20);

    // Address wrap on both ports.
    d0 = done_cnt; w0 = wr_cnt;
    launch(12'hFFE, 12'hFFF, 13'd4);
    wait_done("wrap");
    finish_run("wrap", d0, w0, 4);

    // Zero length.
    d0 = done_cnt; w0 = wr_cnt;
    launch(12'h050, 12'h060, 13'd0);
    check("zero_done", W'(done), 1);
    check("zero_busy", W'(busy), 0);
    check("zero_rd_en", W'(bus.rd_en), 0);
    tick();
    check("zero_done_falls", W'(done), 0);
    finish_run("zero", d0, w0, 0);

    // Start during a run is ignored.
    d0 = done_cnt; w0 = wr_cnt;
    launch(12'h020, 12'h400, 13'd8);
    repeat (3) tick();
    cfg_src_base = 12'h700; cfg_dst_base = 12'h710; cfg_len = 13'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ign");
    finish_run("ign", d0, w0, 8);

    // Reset mid-operation.
    launch(12'h080, 12'h500, 13'd16);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    check("mid_rst_busy", W'(busy), 0);
    check("mid_rst_done", W'(done), 0);
    check("mid_rst_rd_en", W'(bus.rd_en), 0);
    check("mid_rst_wr_valid", W'(bus.wr_valid), 0);
    check("mid_rst_rd_addr", W'(bus.rd_addr), 0);
    check("mid_rst_wr_addr", W'(bus.wr_addr), 0);
    tick();
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.wr_valid || bus.rd_en) seen++;
    end
    check("post_rst_idle", W'(seen), 0);
    d0 = done_cnt; w0 = wr_cnt;
    launch(12'h0A0, 12'h0B0, 13'd2);
    wait_done("post_rst");
    finish_run("post_rst", d0, w0, 2);

    // Random backpressure.
    d0 = done_cnt; w0 = wr_cnt;
    rand_mode = 1'b1;
    launch(12'h200, 12'h600, 13'd64);
    wait_done("rand");
    rand_mode = 1'b0;
    finish_run("rand", d0, w0, 64);
  endtask

  initial begin
    bus.wr_ready = 1'b1;
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
      forever begin
        @(posedge clk);
        #2;
        bus.wr_ready = rand_mode ? ($urandom_range(0, 1) == 1) : ready_level;
      end
      begin
        stimulus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    join_any
  end

endmodule
